ghost_collision_ctrl: RTL and testbench

- Consumes the positions produced by Pac-Man and ghost movement blocks, detects a Pac-Man/ghost overlap, and manages lives.
- Drives the movers' reset and freeze controls, so the movers act as initiators of position updates and this block acts as the responder.
- Runs the play/caught/respawn/game-over sequence, timed in frames through frame_stb.
- Sits between the movers and the top-level game logic on the VGA pixel clock.

---
 rtl/ghost_collision_ctrl_pkg.sv | 22 ++
 rtl/ghost_collision_ctrl_actor_overlap.sv | 37 +++
 rtl/ghost_collision_ctrl.sv | 134 +++++++++++++
 tb/tb_ghost_collision_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ghost_collision_ctrl_pkg.sv
// Shared game-state type and default tuning constants for the Pac-Man collision
// and lives controller.
package ghost_collision_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    CAUGHT,
    RESPAWN,
    GAME_OVER
  } game_state_t;

  localparam int unsigned DEF_NUM_LIVES      = 3;
  localparam int unsigned DEF_HIT_DIST       = 4;
  localparam int unsigned DEF_FREEZE_FRAMES  = 120;
  localparam int unsigned DEF_RESPAWN_FRAMES = 60;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ghost_collision_ctrl_actor_overlap.sv
// Registered overlap test between two actors: |dx| < HIT_DIST and |dy| < HIT_DIST.
// Differences are taken at 10 bits so screen edges never wrap into a hit.
module actor_overlap
  import ghost_collision_ctrl_pkg::*;
#(
  parameter int unsigned HIT_DIST = DEF_HIT_DIST
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [8:0] i_x_a,
  input  logic [8:0] i_y_a,
  input  logic [8:0] i_x_b,
  input  logic [8:0] i_y_b,
  output logic       o_hit
);

  logic signed [9:0] w_dx;
  logic signed [9:0] w_dy;
  logic        [9:0] w_adx;
  logic        [9:0] w_ady;
  logic              w_hit;
  logic              r_hit;

  assign w_dx  = $signed({1'b0, i_x_a}) - $signed({1'b0, i_x_b});
  assign w_dy  = $signed({1'b0, i_y_a}) - $signed({1'b0, i_y_b});
  assign w_adx = w_dx[9] ? 10'(-w_dx) : 10'(w_dx);
  assign w_ady = w_dy[9] ? 10'(-w_dy) : 10'(w_dy);
  assign w_hit = (w_adx < 10'(HIT_DIST)) && (w_ady < 10'(HIT_DIST));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_hit <= 1'b0;
    else       r_hit <= w_hit;
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/ghost_collision_ctrl.sv
// Pac-Man/ghost collision detect plus lives and play/caught/respawn/game-over
// sequencing; drives the movers' reset and freeze controls.
module ghost_collision_ctrl
  import ghost_collision_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LIVES      = DEF_NUM_LIVES,
  parameter int unsigned HIT_DIST       = DEF_HIT_DIST,
  parameter int unsigned FREEZE_FRAMES  = DEF_FREEZE_FRAMES,
  parameter int unsigned RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
  input  logic       vga_pix_clk,
  input  logic       rst,
  input  logic       frame_stb,
  input  logic       start,
  input  logic [8:0] x_pac,
  input  logic [8:0] y_pac,
  input  logic [8:0] x_pink,
  input  logic [8:0] y_pink,
  output logic       actors_rst,
  output logic       freeze,
  output logic [2:0] lives,
  output logic       caught_pulse,
  output logic       game_over
);

  localparam int unsigned CntMax = max_u(FREEZE_FRAMES, RESPAWN_FRAMES);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] FreezeLast  = CntW'(FREEZE_FRAMES - 1);
  localparam logic [CntW-1:0] RespawnLast = CntW'(RESPAWN_FRAMES - 1);

  game_state_t       r_state, w_state_d;
  logic [2:0]        r_lives, w_lives_d;
  logic [CntW-1:0]   r_frame_cnt, w_cnt_d;
  logic              r_pulse, w_pulse_d;
  logic              w_hit_q;

  actor_overlap #(
    .HIT_DIST (HIT_DIST)
  ) u_overlap (
    .i_clk (vga_pix_clk),
    .i_rst (rst),
    .i_x_a (x_pac),
    .i_y_a (y_pac),
    .i_x_b (x_pink),
    .i_y_b (y_pink),
    .o_hit (w_hit_q)
  );

  always_ff @(posedge vga_pix_clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lives     <= 3'(NUM_LIVES);
      r_frame_cnt <= '0;
      r_pulse     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_lives     <= w_lives_d;
      r_frame_cnt <= w_cnt_d;
      r_pulse     <= w_pulse_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_lives_d = r_lives;
    w_cnt_d   = r_frame_cnt;
    w_pulse_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_d = PLAY;
          w_lives_d = 3'(NUM_LIVES);
          w_cnt_d   = '0;
        end
      end
      PLAY: begin
        // Catches are only evaluated on frame boundaries.
        if (frame_stb && w_hit_q) begin
          w_lives_d = r_lives - 3'd1;
          w_pulse_d = 1'b1;
          w_cnt_d   = '0;
          w_state_d = (r_lives == 3'd1) ? GAME_OVER : CAUGHT;
        end
      end
      CAUGHT: begin
        if (frame_stb) begin
          if (r_frame_cnt == FreezeLast) begin
            w_state_d = RESPAWN;
            w_cnt_d   = '0;
          end else if (r_frame_cnt != '1) begin
            w_cnt_d = r_frame_cnt + CntW'(1);
          end
        end
      end
      RESPAWN: begin
        if (frame_stb) begin
          if (r_frame_cnt == RespawnLast) begin
            w_state_d = PLAY;
            w_cnt_d   = '0;
          end else if (r_frame_cnt != '1) begin
            w_cnt_d = r_frame_cnt + CntW'(1);
          end
        end
      end
      GAME_OVER: begin
        w_lives_d = 3'd0;
        if (start) begin
          w_state_d = RESPAWN;
          w_lives_d = 3'(NUM_LIVES);
          w_cnt_d   = '0;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    actors_rst = 1'b0;
    freeze     = 1'b1;
    game_over  = 1'b0;
    case (r_state)
      IDLE:      actors_rst = 1'b1;
      PLAY:      freeze     = 1'b0;
      CAUGHT:    actors_rst = 1'b0;
      RESPAWN:   actors_rst = 1'b1;
      GAME_OVER: game_over  = 1'b1;
      default:   actors_rst = 1'b1;
    endcase
  end

  assign lives        = r_lives;
  assign caught_pulse = r_pulse;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Directed bench for ghost_collision_ctrl; catches are scoreboarded as expected
// lives values queued at stimulus time and popped on each caught_pulse.
module tb_ghost_collision_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_stb;
  logic       start;
  logic [8:0] x_pac, y_pac, x_pink, y_pink;
  logic       actors_rst, freeze, caught_pulse, game_over;
  logic [2:0] lives;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  ghost_collision_ctrl dut (
    .vga_pix_clk  (clk),
    .rst          (rst),
    .frame_stb    (frame_stb),
    .start        (start),
    .x_pac        (x_pac),
    .y_pac        (y_pac),
    .x_pink       (x_pink),
    .y_pink       (y_pink),
    .actors_rst   (actors_rst),
    .freeze       (freeze),
    .lives        (lives),
    .caught_pulse (caught_pulse),
    .game_over    (game_over)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle(input logic stb);
    int exp_l;
    frame_stb = stb;
    @(posedge clk);
    #1;
    frame_stb = 1'b0;
    if (caught_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_l = exp_q.pop_front();
        check("lives_at_pulse", int'(lives), exp_l);
      end
    end
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1);
  endtask

  task automatic ghost(input int gx, input int gy);
    x_pink = 9'(gx);
    y_pink = 9'(gy);
  endtask

  task automatic chk_out(input string tag, input int ar, input int fr, input int go,
                         input int lv);
    check({tag, "_actors_rst"}, int'(actors_rst), ar);
    check({tag, "_freeze"},     int'(freeze),     fr);
    check({tag, "_game_over"},  int'(game_over),  go);
    check({tag, "_lives"},      int'(lives),      lv);
  endtask

  initial begin
    rst = 1'b1; frame_stb = 1'b0; start = 1'b0;
    x_pac = 9'd100; y_pac = 9'd100;
    ghost(300, 300);
    #12;
    chk_out("reset", 1, 1, 0, 3);
    check("reset_pulse", int'(caught_pulse), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b0);
    chk_out("idle", 1, 1, 0, 3);

    start = 1'b1; cycle(1'b0); start = 1'b0;
    chk_out("play", 0, 0, 0, 3);

    // Near miss (dx = 4) and screen-edge pair must not hit.
    ghost(104, 100); cycle(1'b0); cycle(1'b1);
    chk_out("near_miss", 0, 0, 0, 3);
    x_pac = 9'd0; ghost(511, 100); cycle(1'b0); cycle(1'b1);
    chk_out("no_wrap", 0, 0, 0, 3);
    x_pac = 9'd100;

    // Overlap held with no strobe.
    ghost(103, 97);
    for (int i = 0; i < 1000; i++) cycle(1'b0);
    chk_out("no_stb", 0, 0, 0, 3);

    exp_q.push_back(2);
    cycle(1'b1);
    check("catch1_pulse", int'(caught_pulse), 1);
    chk_out("caught1", 0, 1, 0, 2);
    ghost(300, 300);
    cycle(1'b0);
    check("pulse_one_cycle", int'(caught_pulse), 0);

    strobes(119);
    chk_out("caught_119", 0, 1, 0, 2);
    strobes(1);
    chk_out("respawn", 1, 1, 0, 2);
    strobes(59);
    chk_out("respawn_59", 1, 1, 0, 2);
    strobes(1);
    chk_out("play2", 0, 0, 0, 2);

    ghost(97, 103); cycle(1'b0);
    exp_q.push_back(1);
    cycle(1'b1);
    chk_out("caught2", 0, 1, 0, 1);
    ghost(300, 300);
    strobes(180);
    chk_out("play3", 0, 0, 0, 1);

    ghost(100, 100); cycle(1'b0);
    exp_q.push_back(0);
    cycle(1'b1);
    check("gameover_lives", int'(lives), 0);
    check("gameover_flag", int'(game_over), 1);
    check("gameover_freeze", int'(freeze), 1);
    strobes(5);
    check("gameover_hold", int'(game_over), 1);

    start = 1'b1; cycle(1'b0); start = 1'b0;
    chk_out("restart", 1, 1, 0, 3);
    ghost(300, 300);
    strobes(60);
    chk_out("play4", 0, 0, 0, 3);

    ghost(101, 101); cycle(1'b0);
    exp_q.push_back(2);
    cycle(1'b1);
    ghost(300, 300);
    strobes(50);
    chk_out("caught_50", 0, 1, 0, 2);
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 1, 1, 0, 3);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1);
    chk_out("idle_after_rst", 1, 1, 0, 3);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
